// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: phase encoding and the 640x480@60 mode numbers.
package vga_timing_pkg;

    // Region within one axis period, in the order it is traversed.
    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SYN = 2'd2,
        PH_BP  = 2'd3
    } phase_e;

    // Horizontal axis, 640x480@60 (units are pixels).
    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    // Vertical axis, 640x480@60 (units are lines).
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/sync_axis_timer.sv
// One-axis VGA timing generator: position counter, region FSM, registered
// active/sync flags and a combinational carry so two instances can cascade.
module sync_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE   = 640,
    parameter int FRONT    = 16,
    parameter int SYNC     = 96,
    parameter int BACK     = 48,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] cnt,
    output logic          active,
    output logic          sync,
    output logic [1:0]    phase,
    output logic          wrap
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    // Reject geometries that cannot be counted in CW bits or that have an empty region.
    if ((ACTIVE < 1) || (FRONT < 1) || (SYNC < 1) || (BACK < 1) ||
        (CW < 1) || (CW > 30) || (TOTAL > (1 << CW))) begin : g_bad_config
        $error("sync_axis_timer: illegal geometry (fields must be >= 1 and total must fit in CW bits)");
    end

    localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
    localparam logic [CW-1:0] E_ACT = CW'(ACTIVE);
    localparam logic [CW-1:0] E_FP  = CW'(ACTIVE + FRONT);
    localparam logic [CW-1:0] E_SYN = CW'(ACTIVE + FRONT + SYNC);

    logic [CW-1:0] cnt_q, cnt_d;
    phase_e        phase_q, phase_d;
    logic          active_q, active_d;
    logic          sync_q, sync_d;

    // Next count and next region; flags are decoded from the next region so
    // they land in their registers on the same edge as the count.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (ce) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            unique case (phase_q)
                PH_ACT: if (cnt_d == E_ACT) phase_d = PH_FP;
                PH_FP:  if (cnt_d == E_FP)  phase_d = PH_SYN;
                PH_SYN: if (cnt_d == E_SYN) phase_d = PH_BP;
                PH_BP:  if (cnt_d == '0)    phase_d = PH_ACT;
            endcase
        end
        active_d = (phase_d == PH_ACT);
        sync_d   = (phase_d == PH_SYN) ? SYNC_POL : !SYNC_POL;
    end

    // State register; reset parks the axis at the start of the active region.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            cnt_q    <= '0;
            phase_q  <= PH_ACT;
            active_q <= 1'b1;
            sync_q   <= !SYNC_POL;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            active_q <= active_d;
            sync_q   <= sync_d;
        end
    end

    assign cnt    = cnt_q;
    assign phase  = phase_q;
    assign active = active_q;
    assign sync   = sync_q;
    assign wrap   = ce && !rst && (cnt_q == LAST);

endmodule

// File: tb/tb_sync_axis_timer.sv
// Self-checking bench for sync_axis_timer: a default-geometry instance plus a
// cascaded pair (tiny 4/1/1/1 horizontal driving a 480/10/2/33 vertical).
module tb_sync_axis_timer;

    typedef struct {
        logic rst;
        logic ce;
        int   expCnt;
        logic expWrap;
    } vec_t;

    logic clk = 1'b0;

    // Free-running pixel clock, 10 time units per cycle.
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, ce0 = 1'b0;
    logic [9:0] cnt0;
    logic       act0, sync0, wrap0;
    logic [1:0] ph0;

    logic       rstS = 1'b1;
    logic [9:0] cntS, cntV;
    logic       actS, syncS, wrapS, actV, syncV, wrapV;
    logic [1:0] phS, phV;

    int checks = 0;
    int errors = 0;
    int pos0   = 0;
    int posS   = 0;
    int posV   = 0;

    sync_axis_timer dut0 (
        .pixel_clk(clk), .rst(rst0), .ce(ce0),
        .cnt(cnt0), .active(act0), .sync(sync0), .phase(ph0), .wrap(wrap0)
    );

    sync_axis_timer #(
        .ACTIVE(4), .FRONT(1), .SYNC(1), .BACK(1), .SYNC_POL(1'b1), .CW(10)
    ) dutS (
        .pixel_clk(clk), .rst(rstS), .ce(1'b1),
        .cnt(cntS), .active(actS), .sync(syncS), .phase(phS), .wrap(wrapS)
    );

    sync_axis_timer #(
        .ACTIVE(480), .FRONT(10), .SYNC(2), .BACK(33), .SYNC_POL(1'b0), .CW(10)
    ) dutV (
        .pixel_clk(clk), .rst(rstS), .ce(wrapS),
        .cnt(cntV), .active(actV), .sync(syncV), .phase(phV), .wrap(wrapV)
    );

    function automatic logic [1:0] regionOf(input int p, input int a, input int f, input int s);
        if (p < a)             return 2'd0;
        else if (p < a + f)    return 2'd1;
        else if (p < a + f + s) return 2'd2;
        else                   return 2'd3;
    endfunction

    task automatic checkValue(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Compare the default instance against the position model (called at negedge).
    task automatic checkOutput0(input logic r, input logic c);
        logic [1:0] eph;
        logic       eAct, eSync, eWrap;
        eph   = regionOf(pos0, 640, 16, 96);
        eAct  = (pos0 < 640);
        eSync = !((pos0 >= 656) && (pos0 < 752));
        eWrap = c && !r && (pos0 == 799);
        checks++;
        if (cnt0 !== 10'(pos0) || ph0 !== eph || act0 !== eAct || sync0 !== eSync || wrap0 !== eWrap) begin
            errors++;
            $display("[TB] FAIL axis0: got cnt=%0d ph=%0d act=%b sync=%b wrap=%b, expected cnt=%0d ph=%0d act=%b sync=%b wrap=%b",
                     cnt0, ph0, act0, sync0, wrap0, pos0, eph, eAct, eSync, eWrap);
        end
    endtask

    task automatic applyStimulus0(input logic r, input logic c);
        rst0 = r;
        ce0  = c;
        @(negedge clk);
        checkOutput0(r, c);
        @(posedge clk);
        if (r)      pos0 = 0;
        else if (c) pos0 = (pos0 + 1) % 800;
        #1;
    endtask

    // Compare the cascaded pair against the line/pixel model (called at negedge).
    task automatic checkOutputS(input logic r);
        logic [1:0] ephS, ephV;
        logic       eWrapS, eWrapV, eSyncV;
        ephS   = regionOf(posS, 4, 1, 1);
        ephV   = regionOf(posV, 480, 10, 2);
        eWrapS = !r && (posS == 6);
        eWrapV = eWrapS && (posV == 524);
        eSyncV = !((posV >= 490) && (posV < 492));
        checks++;
        if (cntS !== 10'(posS) || phS !== ephS || actS !== (posS < 4) || syncS !== (posS == 5) || wrapS !== eWrapS) begin
            errors++;
            $display("[TB] FAIL axisH: got cnt=%0d ph=%0d act=%b sync=%b wrap=%b, expected cnt=%0d ph=%0d act=%b sync=%b wrap=%b",
                     cntS, phS, actS, syncS, wrapS, posS, ephS, (posS < 4), (posS == 5), eWrapS);
        end
        checks++;
        if (cntV !== 10'(posV) || phV !== ephV || actV !== (posV < 480) || syncV !== eSyncV || wrapV !== eWrapV) begin
            errors++;
            $display("[TB] FAIL axisV: got cnt=%0d ph=%0d act=%b sync=%b wrap=%b, expected cnt=%0d ph=%0d act=%b sync=%b wrap=%b",
                     cntV, phV, actV, syncV, wrapV, posV, ephV, (posV < 480), eSyncV, eWrapV);
        end
    endtask

    task automatic applyStimulusS(input logic r);
        rstS = r;
        @(negedge clk);
        checkOutputS(r);
        @(posedge clk);
        if (r) begin
            posS = 0;
            posV = 0;
        end else begin
            if (posS == 6) posV = (posV + 1) % 525;
            posS = (posS + 1) % 7;
        end
        #1;
    endtask

    // Main test sequence.
    initial begin
        vec_t vecs[23];
        int   wrapCount, syncLowCount, activeCount, wrapAtCnt;
        int   vWrapCount, vSyncLowCycles, vWrapWithH;
        int   seqS[7];

        for (int i = 0; i < 20; i++) begin
            vecs[i] = '{rst: 1'b0, ce: (i % 2 == 0), expCnt: i / 2 + 1, expWrap: 1'b0};
        end
        vecs[20] = '{rst: 1'b1, ce: 1'b1, expCnt: 0, expWrap: 1'b0};
        vecs[21] = '{rst: 1'b0, ce: 1'b1, expCnt: 1, expWrap: 1'b0};
        vecs[22] = '{rst: 1'b0, ce: 1'b0, expCnt: 1, expWrap: 1'b0};

        rst0 = 1'b1;
        ce0  = 1'b0;
        rstS = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state of the default instance.
        checkValue("reset cnt", int'(cnt0), 0);
        checkValue("reset phase", int'(ph0), 0);
        checkValue("reset active", int'(act0), 1);
        checkValue("reset sync", int'(sync0), 1);
        checkValue("reset wrap", int'(wrap0), 0);

        // Table: ce toggling 1,0,... then reset overriding ce.
        for (int i = 0; i < 23; i++) begin
            rst0 = vecs[i].rst;
            ce0  = vecs[i].ce;
            @(negedge clk);
            checkValue($sformatf("vec%0d wrap", i), int'(wrap0), int'(vecs[i].expWrap));
            @(posedge clk);
            #1;
            checkValue($sformatf("vec%0d cnt", i), int'(cnt0), vecs[i].expCnt);
            checkValue($sformatf("vec%0d phase", i), int'(ph0), 0);
        end
        pos0 = vecs[22].expCnt;

        // One full period with continuous ce from reset.
        applyStimulus0(1'b1, 1'b1);
        wrapCount = 0; syncLowCount = 0; activeCount = 0; wrapAtCnt = -1;
        for (int i = 0; i < 800; i++) begin
            rst0 = 1'b0;
            ce0  = 1'b1;
            @(negedge clk);
            if (wrap0 === 1'b1) begin
                wrapCount++;
                wrapAtCnt = int'(cnt0);
            end
            if (sync0 === 1'b0) syncLowCount++;
            if (act0 === 1'b1)  activeCount++;
            checkOutput0(1'b0, 1'b1);
            @(posedge clk);
            pos0 = (pos0 + 1) % 800;
            #1;
        end
        checkValue("period wrap count", wrapCount, 1);
        checkValue("period wrap position", wrapAtCnt, 799);
        checkValue("period sync-low count", syncLowCount, 96);
        checkValue("period active count", activeCount, 640);
        checkValue("period cnt back to 0", int'(cnt0), 0);

        // Reset in the middle of the sync region, held with ce=1.
        for (int i = 0; i < 700; i++) applyStimulus0(1'b0, 1'b1);
        checkValue("pre-reset cnt", int'(cnt0), 700);
        checkValue("pre-reset phase", int'(ph0), 2);
        for (int i = 0; i < 3; i++) applyStimulus0(1'b1, 1'b1);
        checkValue("held reset cnt", int'(cnt0), 0);
        checkValue("held reset sync", int'(sync0), 1);
        applyStimulus0(1'b0, 1'b0);
        applyStimulus0(1'b0, 1'b1);

        // Randomised ce gating with rare resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus0(($urandom_range(0, 1499) == 0), ($urandom_range(0, 3) != 0));
        end

        // Cascade: tiny horizontal (period 7) driving a 525-line vertical.
        applyStimulusS(1'b1);
        vWrapCount = 0; vSyncLowCycles = 0; vWrapWithH = 0;
        for (int i = 0; i < 525 * 7; i++) begin
            rstS = 1'b0;
            @(negedge clk);
            if (wrapV === 1'b1) begin
                vWrapCount++;
                if (wrapS === 1'b1 && cntV == 10'd524 && cntS == 10'd6) vWrapWithH++;
            end
            if (syncV === 1'b0) vSyncLowCycles++;
            if (i < 7) seqS[i] = int'(phS);
            checkOutputS(1'b0);
            @(posedge clk);
            if (posS == 6) posV = (posV + 1) % 525;
            posS = (posS + 1) % 7;
            #1;
        end
        checkValue("V wrap count", vWrapCount, 1);
        checkValue("V wrap with H wrap", vWrapWithH, 1);
        checkValue("V sync-low cycles", vSyncLowCycles, 2 * 7);
        checkValue("H phase seq 0", seqS[0], 0);
        checkValue("H phase seq 4", seqS[4], 1);
        checkValue("H phase seq 5", seqS[5], 2);
        checkValue("H phase seq 6", seqS[6], 3);
        checkValue("V back to line 0", int'(cntV), 0);
        for (int i = 0; i < 10; i++) applyStimulusS(1'b0);
        applyStimulusS(1'b1);
        applyStimulusS(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_axis_timer.md
Name: sync_axis_timer

Overview:
- Parametrised, cascadable VGA timing generator for one axis. It is the successor to the fixed horizontal-only sync block.
- One instance is configured as the horizontal axis and ticks every pixel. A second instance is configured as the vertical axis and ticks on the first instance's wrap pulse.
- Outputs are the sync pulse, the active-video flag and the position counter. These feed the pixel/colour logic and the VGA pins.

Parameters:
- ACTIVE, 640, visible units per period (pixels or lines)
- FRONT, 16, front-porch units
- SYNC, 96, sync-pulse units
- BACK, 48, back-porch units
- SYNC_POL, 0, asserted level of sync (0 = active-low, as in 640x480@60)
- CW, 10, counter width; elaboration must fail unless ACTIVE+FRONT+SYNC+BACK <= 2**CW and every field is >= 1

Ports:
- pixel_clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  count enable: tie to 1 for the horizontal axis, connect to the horizontal wrap for the vertical axis
- cnt  out  CW  position within the period, 0..TOTAL-1
- active  out  1  high while cnt < ACTIVE
- sync  out  1  at level SYNC_POL during the sync region, !SYNC_POL otherwise
- phase  out  2  current region: 0=ACT, 1=FP, 2=SYN, 3=BP
- wrap  out  1  carry: high when ce=1 and cnt==TOTAL-1

Behaviour:
- TOTAL = ACTIVE+FRONT+SYNC+BACK (800 with the defaults). Region boundaries, in count units:
  - E_ACT = ACTIVE
  - E_FP = ACTIVE+FRONT
  - E_SYN = E_FP+SYNC
- Reset (rst=1 on a rising edge of pixel_clk):
  - cnt=0, phase=ACT, active=1, sync=!SYNC_POL.
  - wrap is forced to 0 while rst=1.
  - rst overrides ce.
- Counting, on each rising edge with rst=0 and ce=1:
  - cnt <= (cnt==TOTAL-1) ? 0 : cnt+1.
  - Arithmetic is unsigned, CW bits, with no overflow beyond TOTAL-1.
- Phase FSM, advancing only when ce=1:
  - ACT -> FP when next cnt == E_ACT.
  - FP -> SYN when next cnt == E_FP.
  - SYN -> BP when next cnt == E_SYN.
  - BP -> ACT when next cnt == 0 (wrap).
  - Otherwise phase holds.
  - phase, cnt, active and sync are all registered and updated on the same edge, so they are always mutually consistent, with zero skew between them.
- active = (phase==ACT); sync = (phase==SYN) ? SYNC_POL : !SYNC_POL. Both are register outputs with no decode glitches.
- wrap is combinational from the registered cnt and ce:
  - High for exactly one cycle per period when ce is continuous.
  - When ce is gated, wrap is high only in cycles where ce=1 and cnt==TOTAL-1.
- ce=0: every register holds its value and wrap=0.
- Cascade: the vertical instance's ce is driven by the horizontal instance's wrap. The vertical counter therefore advances on the same edge on which horizontal cnt returns to 0.
- Reset mid-period: the next cycle must show cnt=0, phase=ACT and sync inactive, regardless of the previous phase.
- Any field equal to 1 (one-unit region) must still produce exactly one unit in that phase.

Decomposition:
- Shared package vga_timing_pkg holds:
  - phase encoding constants PH_ACT=0, PH_FP=1, PH_SYN=2, PH_BP=3.
  - Standard mode constants for 640x480@60: H = 640/16/96/48; V = 480/10/2/33, TOTAL 525.
- No sub-module: a single counter plus FSM.
- A top-level vga_timing wrapper instantiates two sync_axis_timer instances. That wrapper is a separate block and not part of this one.

Test Plan:
- Reset then ce=1 for 800 cycles, defaults:
  - active high for cnt 0..639.
  - sync low exactly for cnt 656..751.
  - wrap high only in the cycle where cnt==799.
  - cnt returns to 0 on the next edge.
- Cascade H (defaults) with V (480/10/2/33), run 525*800 cycles:
  - V sync low for lines 490..491 only.
  - V active for lines 0..479.
  - V wraps once, together with the H wrap at line 524 / pixel 799.
- ce toggling 1,0,1,0 from reset:
  - cnt advances only on ce=1 edges.
  - After 20 cycles cnt==10.
  - wrap is never high with ce=0.
- Assert rst at cnt=700 (phase SYN):
  - Next cycle: cnt=0, phase=0, active=1, sync=1.
  - rst held with ce=1 keeps the outputs frozen.
- ACTIVE=4, FRONT=1, SYNC=1, BACK=1, SYNC_POL=1:
  - Period is 7.
  - sync high only at cnt=5.
  - phase sequence 0,0,0,0,1,2,3 repeats.
- Illegal configuration (TOTAL=1100 with CW=10) -> elaboration error.
